sr_latch_driver: RTL and testbench
==================================

// Module: sr_latch_driver
// PURPOSE
//   Upstream driver stage for the gated SR latch. Takes two raw push-button inputs (set, reset)
//   and synchronises and debounces them. Turns each clean press into one well-formed latch command:
//   set/reset is set up with enable low, enable is pulsed, then set/reset is held. Guarantees
//   enable is never high while set and reset are both high, so the latch never sees the forbidden input.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable samples needed to accept a button level change (>=1)
//   SETUP_CYCLES     1  cycles set/reset is driven with enable low before the enable pulse (>=1)
//   PULSE_CYCLES     2  cycles latchEnable is held high (>=1)
//   COUNT_WIDTH      8  width of commandCount (STATUS_COUNT_EN only)
// PORTS
//   clock          in   1            single system clock, rising edge
//   reset          in   1            synchronous, active-high reset
//   setButton      in   1            raw asynchronous set button
//   resetButton    in   1            raw asynchronous reset button
//   latchEnable    out  1            to latch enable
//   latchSet       out  1            to latch set
//   latchReset     out  1            to latch reset
//   busy           out  1            high while a command is in flight (state != IDLE)
//   conflict       out  1            1-cycle pulse: simultaneous set+reset requests discarded
//   commandCount   out  COUNT_WIDTH  commands completed (STATUS_COUNT_EN only)
// BEHAVIOUR
//   Clock and reset: one clock domain. Reset is synchronous and active-high.
//   Reset: all outputs 0, FSM=IDLE, sync/debounce regs 0, pending flags 0, counters 0.
//   Input path per button:
//   - 2-flop synchroniser.
//   - Debounce counter: counts while the synced level differs from the accepted level.
//     Clears on any sample equal to the accepted level.
//     On reaching DEBOUNCE_CYCLES, the accepted level updates.
//   - Rising edge of the accepted level produces a 1-cycle request.
//   - Latency from a stable button edge to the request: 2 + DEBOUNCE_CYCLES cycles.
//   Pending flags (one per button):
//   - A request sets its pending flag.
//   - A further request while the flag is already set is absorbed (no queueing beyond depth 1).
//   Arbitration, evaluated only in IDLE:
//   - Both pending: clear both, pulse conflict, stay IDLE.
//   - One pending: load command (SET or RESET), clear that flag, go to SETUP.
//   - Requests arriving in the same cycle as arbitration are seen next cycle.
//   FSM: IDLE -> SETUP -> PULSE -> HOLD -> IDLE
//   - IDLE: enable=0, set=0, reset=0.
//   - SETUP: SETUP_CYCLES cycles. Selected line (latchSet or latchReset) = 1, enable = 0.
//   - PULSE: PULSE_CYCLES cycles. Selected line = 1, enable = 1.
//   - HOLD: 1 cycle. Selected line = 1, enable = 0. Next state IDLE.
//   - The unselected line is 0 in all states. latchSet & latchReset is never 1.
//   Timing:
//   - Command duration from leaving IDLE: SETUP_CYCLES + PULSE_CYCLES + 1 cycles.
//   - Back-to-back pending command starts on the cycle after returning to IDLE (one IDLE cycle).
//   Outputs are registered (driven from the state/command regs), so no glitching.
//   Cross requests: a request for the opposite command during busy is held pending and executed
//   next; no conflict is flagged.
//   Reset mid-command: next edge forces IDLE and all outputs 0. The in-flight command is
//   abandoned and pending requests are lost.
//   State counter: sized $clog2(max(SETUP_CYCLES,PULSE_CYCLES)+1). Reloads on each state entry.
// CONFIGURATION
//   STATUS_COUNT_EN defined:
//   - commandCount increments by 1 on each HOLD->IDLE transition.
//   - Wraps modulo 2^COUNT_WIDTH.
//   - Reset clears it to 0. Conflicts are not counted.
//   STATUS_COUNT_EN undefined:
//   - commandCount port and counter logic absent; all other behaviour identical.
// TESTING (defaults unless noted)
//   1 Reset: assert reset 3 cycles with buttons toggling -> all outputs 0, busy=0, no commands.
//   2 Clean set press: setButton 0->1 held -> busy rises 7 cycles after the edge. latchSet=1 4 cycles;
//     latchEnable=1 on cycles 2-3 only; latchReset=0 throughout.
//   3 Bounce: setButton toggles every cycle for 10 cycles, then settles at 1 -> exactly one SET
//     command, and only after 4 stable samples.
//   4 Conflict: both buttons rise in the same cycle -> conflict pulses once, no enable pulse, busy=0.
//   5 Cross request: reset press accepted during a SET PULSE -> SET completes, 1 IDLE cycle, then a
//     RESET command runs; latchSet & latchReset is never 1.
//   6 Reset mid-PULSE: reset asserted while latchEnable=1 -> all outputs 0 next edge; pending dropped.
//     With STATUS_COUNT_EN and COUNT_WIDTH=2: 5 commands -> commandCount=1 (wrap).

Source files
------------

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Upstream driver for a gated SR latch. Each raw push button passes through a
//   2-flop synchroniser and a debouncer. The rising edge of a button's accepted
//   level becomes a request. Requests are turned into one well-formed latch
//   command: the selected line is set up with enable low, then enable is pulsed,
//   then the line is held for one cycle. Requests for set and reset that are
//   both pending are discarded together, so the latch never sees both lines high.
//
//   Optional feature macro: STATUS_COUNT_EN adds the commandCount port. It counts
//   completed commands modulo 2^COUNT_WIDTH.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   setButton    in   raw asynchronous set button
//   resetButton  in   raw asynchronous reset button
//   latchEnable  out  latch enable
//   latchSet     out  latch set line
//   latchReset   out  latch reset line
//   busy         out  high while a command is in flight
//   conflict     out  1-cycle pulse when simultaneous set+reset requests are dropped
//   commandCount out  completed command count (STATUS_COUNT_EN only)
module sr_latch_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SETUP_CYCLES    = 1,
  parameter int unsigned PULSE_CYCLES    = 2
`ifdef STATUS_COUNT_EN
  , parameter int unsigned COUNT_WIDTH   = 8
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic setButton,
  input  logic resetButton,
  output logic latchEnable,
  output logic latchSet,
  output logic latchReset,
  output logic busy,
  output logic conflict
`ifdef STATUS_COUNT_EN
  , output logic [COUNT_WIDTH-1:0] commandCount
`endif
);

  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MAX_PHASE = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned PH_W      = $clog2(MAX_PHASE + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] SETUP_LOAD = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] PULSE_LOAD = PH_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  typedef enum logic {CMD_SET, CMD_RESET} cmd_t;

  // Bit 0 carries the set button, bit 1 the reset button.
  logic [1:0]      buttons;
  logic [1:0]      sync1, sync2, level, req;
  logic [1:0]      pending, pending_clr;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state, state_n;
  cmd_t            cmd, cmd_n;
  logic [PH_W-1:0] ph, ph_n;
  logic            conflict_n;

  assign buttons = {resetButton, setButton};

  // A request is the accepting sample of a 0->1 level change. It lands in the
  // pending flag on the same edge that the accepted level updates.
  always_comb begin
    req = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      req[b] = sync2[b] && !level[b] && (db_cnt[b] == DB_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        db_cnt[b] <= '0;
      end
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      for (int unsigned b = 0; b < 2; b++) begin
        if (sync2[b] == level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          level[b]  <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n     = state;
    cmd_n       = cmd;
    ph_n        = ph;
    pending_clr = '0;
    conflict_n  = 1'b0;
    case (state)
      IDLE: begin
        if (&pending) begin
          pending_clr = '1;
          conflict_n  = 1'b1;
        end else if (pending[0]) begin
          pending_clr = 2'b01;
          cmd_n       = CMD_SET;
          state_n     = SETUP;
          ph_n        = SETUP_LOAD;
        end else if (pending[1]) begin
          pending_clr = 2'b10;
          cmd_n       = CMD_RESET;
          state_n     = SETUP;
          ph_n        = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (ph == '0) begin
          state_n = PULSE;
          ph_n    = PULSE_LOAD;
        end else begin
          ph_n = ph - 1'b1;
        end
      end
      PULSE: begin
        if (ph == '0) begin
          state_n = HOLD;
          ph_n    = '0;
        end else begin
          ph_n = ph - 1'b1;
        end
      end
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they change only on
  // the clock edge and line up exactly with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cmd         <= CMD_SET;
      ph          <= '0;
      pending     <= '0;
      latchEnable <= 1'b0;
      latchSet    <= 1'b0;
      latchReset  <= 1'b0;
      busy        <= 1'b0;
      conflict    <= 1'b0;
    end else begin
      state       <= state_n;
      cmd         <= cmd_n;
      ph          <= ph_n;
      pending     <= (pending & ~pending_clr) | req;
      latchEnable <= (state_n == PULSE);
      latchSet    <= (state_n != IDLE) && (cmd_n == CMD_SET);
      latchReset  <= (state_n != IDLE) && (cmd_n == CMD_RESET);
      busy        <= (state_n != IDLE);
      conflict    <= conflict_n;
    end
  end

`ifdef STATUS_COUNT_EN
  // HOLD always returns to IDLE, so being in HOLD marks a completed command.
  always_ff @(posedge clock) begin
    if (reset) begin
      commandCount <= '0;
    end else if (state == HOLD) begin
      commandCount <= commandCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver
//   Self-checking bench for sr_latch_driver. A cycle-level reference model
//   (run-length debounce, pending flags, command position counter) pushes the
//   expected outputs after every clock edge into a queue. A monitor pops them on
//   the falling edge and compares. Directed scenarios add event-level checks:
//   reset, clean press latency, bounce, conflict, cross request, and reset
//   mid-pulse. A randomized phase follows the directed scenarios.
module tb_sr_latch_driver;
  localparam int D = 4;
  localparam int S = 1;
  localparam int P = 2;
`ifdef STATUS_COUNT_EN
  localparam int CW = 8;
`endif

  logic clock = 1'b0;
  logic reset, setButton, resetButton;
  logic latchEnable, latchSet, latchReset, busy, conflict;
`ifdef STATUS_COUNT_EN
  logic [CW-1:0] commandCount;
`endif

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(D),
    .SETUP_CYCLES(S),
    .PULSE_CYCLES(P)
`ifdef STATUS_COUNT_EN
    , .COUNT_WIDTH(CW)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .setButton(setButton),
    .resetButton(resetButton),
    .latchEnable(latchEnable),
    .latchSet(latchSet),
    .latchReset(latchReset),
    .busy(busy),
    .conflict(conflict)
`ifdef STATUS_COUNT_EN
    , .commandCount(commandCount)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] o;   // {enable, set, reset, busy, conflict}
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int en_rises = 0;
  int conf_pulses = 0;

  // Reference model state
  bit [1:0] m_s1, m_s2, m_acc, m_pend;
  int       m_run[2];
  int       m_pos = -1;   // -1 idle, else cycle index within the command
  bit       m_cmd;        // 0 = set, 1 = reset
  int       m_count = 0;
  bit       m_conf;

  always @(posedge clock) begin : model
    exp_t e;
    bit [1:0] rq, clr, raw;
    bit act;
    raw = {resetButton, setButton};
    rq = '0;
    clr = '0;
    m_conf = 1'b0;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_pend = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_pos = -1; m_cmd = 1'b0; m_count = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (m_s2[b] != m_acc[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_acc[b] = m_s2[b];
            m_run[b] = 0;
            if (m_acc[b]) rq[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      if (m_pos < 0) begin
        if (m_pend == 2'b11) begin
          clr = 2'b11;
          m_conf = 1'b1;
        end else if (m_pend[0]) begin
          clr = 2'b01; m_cmd = 1'b0; m_pos = 0;
        end else if (m_pend[1]) begin
          clr = 2'b10; m_cmd = 1'b1; m_pos = 0;
        end
      end else if (m_pos == S + P) begin
        m_pos = -1;
        m_count++;
      end else begin
        m_pos++;
      end
      m_pend = (m_pend & ~clr) | rq;
      m_s2 = m_s1;
      m_s1 = raw;
    end
    act = (m_pos >= 0);
    e.o = {act && m_pos >= S && m_pos < S + P, act && !m_cmd, act && m_cmd, act, m_conf};
    e.cnt = m_count;
    exp_q.push_back(e);
  end

  bit en_prev = 1'b0;
  always @(negedge clock) begin : monitor
    exp_t e;
    logic [4:0] act;
    act = {latchEnable, latchSet, latchReset, busy, conflict};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t actual=%b required=expected entry", $time, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.o) begin
        errors++;
        $display("FAIL outputs t=%0t en/set/rst/busy/conf actual=%b required=%b", $time, act, e.o);
      end
`ifdef STATUS_COUNT_EN
      checks++;
      if (commandCount !== CW'(e.cnt)) begin
        errors++;
        $display("FAIL commandCount t=%0t actual=%0d required=%0d", $time, commandCount, CW'(e.cnt));
      end
`endif
    end
    checks++;
    if (latchSet === 1'b1 && latchReset === 1'b1) begin
      errors++;
      $display("FAIL set_and_reset t=%0t actual=11 required=not both", $time);
    end
    if (latchEnable === 1'b1 && !en_prev) en_rises++;
    if (conflict === 1'b1) conf_pulses++;
    en_prev = (latchEnable === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_int(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  initial begin : stim
    int e0, c0, lat;
    reset = 1'b1;
    setButton = 1'b0;
    resetButton = 1'b0;

    // 1: reset with buttons toggling
    for (int i = 0; i < 3; i++) begin
      setButton = i[0];
      resetButton = ~i[0];
      cyc(1);
    end
    reset = 1'b0;
    setButton = 1'b0;
    resetButton = 1'b0;
    cyc(10);
    check_int("reset_no_enable", en_rises, 0);
    check_int("reset_busy", int'(busy), 0);

    // 2: clean set press, busy latency from the button edge
    e0 = en_rises;
    setButton = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (busy === 1'b1) begin
        lat = i;
        break;
      end
    end
    check_int("press_latency", lat, 7);
    cyc(10);
    check_int("press_one_cmd", en_rises - e0, 1);
    setButton = 1'b0;
    cyc(12);

    // 3: bounce then settle high
    e0 = en_rises;
    for (int i = 0; i < 10; i++) begin
      setButton = ~setButton;
      cyc(1);
    end
    setButton = 1'b1;
    cyc(30);
    check_int("bounce_one_cmd", en_rises - e0, 1);
    setButton = 1'b0;
    cyc(12);

    // 4: simultaneous presses
    e0 = en_rises;
    c0 = conf_pulses;
    setButton = 1'b1;
    resetButton = 1'b1;
    cyc(20);
    check_int("conflict_pulses", conf_pulses - c0, 1);
    check_int("conflict_no_enable", en_rises - e0, 0);
    check_int("conflict_busy", int'(busy), 0);
    setButton = 1'b0;
    resetButton = 1'b0;
    cyc(12);

    // 5: reset request arrives while a set command is running
    e0 = en_rises;
    c0 = conf_pulses;
    setButton = 1'b1;
    cyc(2);
    resetButton = 1'b1;
    cyc(25);
    check_int("cross_two_cmds", en_rises - e0, 2);
    check_int("cross_no_conflict", conf_pulses - c0, 0);
    setButton = 1'b0;
    resetButton = 1'b0;
    cyc(12);

    // 6: reset while enable is high, with a reset request pending
    e0 = en_rises;
    setButton = 1'b1;
    cyc(3);
    resetButton = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (latchEnable === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL midpulse_wait actual=timeout required=enable high");
    end
    reset = 1'b1;
    setButton = 1'b0;
    resetButton = 1'b0;
    cyc(1);
    check_int("midpulse_outputs", int'({latchEnable, latchSet, latchReset, busy, conflict}), 0);
    reset = 1'b0;
    cyc(20);
    check_int("midpulse_pending_dropped", en_rises - e0, 1);

    // 7: randomized buttons, bounce and occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        reset = 1'b1;
        cyc(int'($urandom_range(1, 2)));
        reset = 1'b0;
      end else if (r < 25) begin
        for (int k = 0; k < int'($urandom_range(2, 8)); k++) begin
          setButton = 1'($urandom);
          resetButton = 1'($urandom);
          cyc(1);
        end
      end else begin
        setButton = 1'($urandom);
        resetButton = 1'($urandom);
        cyc(int'($urandom_range(1, 14)));
      end
    end
    setButton = 1'b0;
    resetButton = 1'b0;
    cyc(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
